// File: rtl/ppu_scanout.sv
// rtl/ppu_scanout.sv - 640x480 scanout of a 320x240 row buffer through a paired-colour palette
module ppu_scanout (
   input  logic        clk,
   input  logic        rst_n,
   output logic [8:0]  rowram_rdaddr,
   input  logic [9:0]  rowram_rddata,
   output logic [8:0]  palram_rdaddr,
   input  logic [63:0] palram_rddata,
   output logic [7:0]  vid_r,
   output logic [7:0]  vid_g,
   output logic [7:0]  vid_b,
   output logic        vid_hsync,
   output logic        vid_vsync,
   output logic        vid_de,
   output logic        row_req,
   output logic [7:0]  row_req_num,
   output logic        vblank_start
);

   logic [9:0]  hcount_q, hcount_d;
   logic [9:0]  vcount_q, vcount_d;
   logic [1:0]  act_sr_q;
   logic [1:0]  hs_sr_q;
   logic [1:0]  vs_sr_q;
   logic        sel_q;
   logic [7:0]  vid_r_q, vid_g_q, vid_b_q;
   logic        vid_de_q, vid_hsync_q, vid_vsync_q;
   logic        row_req_q, row_req_d;
   logic [7:0]  row_req_num_q, row_req_num_d;
   logic        vblank_start_q, vblank_start_d;

   logic        h_active;
   logic        active;
   logic        hs_raw;
   logic        vs_raw;
   logic [31:0] colour;
   logic        unused_pal;

   always_comb begin
      hcount_d = hcount_q + 10'd1;
      vcount_d = vcount_q;
      if (hcount_q == 10'd799) begin
         hcount_d = 10'd0;
         vcount_d = (vcount_q == 10'd524) ? 10'd0 : vcount_q + 10'd1;
      end
   end

   assign h_active      = (hcount_q < 10'd640);
   assign active        = h_active && (vcount_q < 10'd480);
   assign hs_raw        = !((hcount_q >= 10'd656) && (hcount_q <= 10'd751));
   assign vs_raw        = !((vcount_q >= 10'd490) && (vcount_q <= 10'd491));
   assign rowram_rdaddr = h_active ? hcount_q[9:1] : 9'd0;
   assign palram_rdaddr = rowram_rddata[9:1];
   assign colour        = sel_q ? palram_rddata[63:32] : palram_rddata[31:0];
   assign unused_pal    = &{1'b0, colour[31:24]};

   // Requests are launched one cycle early so the pulse lines up with hcount==640.
   always_comb begin
      row_req_d      = (hcount_q == 10'd639) &&
                       ((vcount_q[0] && (vcount_q < 10'd479)) || (vcount_q == 10'd524));
      row_req_num_d  = row_req_num_q;
      if (row_req_d) begin
         row_req_num_d = (vcount_q == 10'd524) ? 8'd0 : vcount_q[8:1] + 8'd1;
      end
      vblank_start_d = (hcount_q == 10'd799) && (vcount_q == 10'd479);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q       <= 10'd0;
         vcount_q       <= 10'd0;
         act_sr_q       <= 2'b00;
         hs_sr_q        <= 2'b11;
         vs_sr_q        <= 2'b11;
         sel_q          <= 1'b0;
         vid_r_q        <= 8'd0;
         vid_g_q        <= 8'd0;
         vid_b_q        <= 8'd0;
         vid_de_q       <= 1'b0;
         vid_hsync_q    <= 1'b1;
         vid_vsync_q    <= 1'b1;
         row_req_q      <= 1'b0;
         row_req_num_q  <= 8'd0;
         vblank_start_q <= 1'b0;
      end else begin
         hcount_q       <= hcount_d;
         vcount_q       <= vcount_d;
         act_sr_q       <= {act_sr_q[0], active};
         hs_sr_q        <= {hs_sr_q[0], hs_raw};
         vs_sr_q        <= {vs_sr_q[0], vs_raw};
         sel_q          <= rowram_rddata[0];
         vid_r_q        <= act_sr_q[1] ? colour[23:16] : 8'd0;
         vid_g_q        <= act_sr_q[1] ? colour[15:8]  : 8'd0;
         vid_b_q        <= act_sr_q[1] ? colour[7:0]   : 8'd0;
         vid_de_q       <= act_sr_q[1];
         vid_hsync_q    <= hs_sr_q[1];
         vid_vsync_q    <= vs_sr_q[1];
         row_req_q      <= row_req_d;
         row_req_num_q  <= row_req_num_d;
         vblank_start_q <= vblank_start_d;
      end
   end

   assign vid_r        = vid_r_q;
   assign vid_g        = vid_g_q;
   assign vid_b        = vid_b_q;
   assign vid_de       = vid_de_q;
   assign vid_hsync    = vid_hsync_q;
   assign vid_vsync    = vid_vsync_q;
   assign row_req      = row_req_q;
   assign row_req_num  = row_req_num_q;
   assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_ppu_scanout.sv
// tb/tb_ppu_scanout.sv - scoreboard bench for ppu_scanout with colour vectors and reset sequences
module tb_ppu_scanout;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [8:0]  rowram_rdaddr;
   logic [9:0]  rowram_rddata = 10'd0;
   logic [8:0]  palram_rdaddr;
   logic [63:0] palram_rddata = 64'd0;
   logic [7:0]  vid_r, vid_g, vid_b;
   logic        vid_hsync, vid_vsync, vid_de;
   logic        row_req;
   logic [7:0]  row_req_num;
   logic        vblank_start;

   ppu_scanout dut (
      .clk(clk), .rst_n(rst_n),
      .rowram_rdaddr(rowram_rdaddr), .rowram_rddata(rowram_rddata),
      .palram_rdaddr(palram_rdaddr), .palram_rddata(palram_rddata),
      .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
      .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
      .row_req(row_req), .row_req_num(row_req_num), .vblank_start(vblank_start)
   );

   always #5 clk = ~clk;

   logic [9:0]  row_mem [0:319];
   logic [63:0] pal_mem [0:511];

   always @(posedge clk) begin
      rowram_rddata <= row_mem[rowram_rdaddr];
      palram_rddata <= pal_mem[palram_rdaddr];
   end

   typedef struct packed {
      logic        de, hs, vs;
      logic [23:0] rgb;
      logic [9:0]  h, v;
   } pix_t;

   typedef struct {
      int          x;
      logic [9:0]  idx;
      logic [8:0]  pa;
      logic [63:0] word;
      logic [23:0] rgb;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   pix_t        exp_q[$];
   int          mh = 0, mv = 0;
   logic [23:0] cap [0:1][0:639];
   bit          cap_en = 1'b1;
   int          exp_pulses = 0, got_pulses = 0;

   task automatic finish_tb();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   function automatic pix_t make_exp(input int h, input int v);
      pix_t        p;
      logic [9:0]  idx;
      logic [63:0] w;
      logic [31:0] c;
      logic        act;
      act   = (h < 640) && (v < 480);
      idx   = row_mem[(h < 640) ? h / 2 : 0];
      w     = pal_mem[idx[9:1]];
      c     = idx[0] ? w[63:32] : w[31:0];
      p.de  = act;
      p.hs  = !((h >= 656) && (h < 752));
      p.vs  = !((v >= 490) && (v < 492));
      p.rgb = act ? c[23:0] : 24'h0;
      p.h   = h[9:0];
      p.v   = v[9:0];
      return p;
   endfunction

   // Reference timing model: one expected pixel pushed per counter value.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mh = 0;
         mv = 0;
         exp_q.delete();
      end else begin
         exp_q.push_back(make_exp(mh, mv));
         if (mh == 799) begin
            mh = 0;
            mv = (mv == 524) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
      end
   end

   pix_t        e;
   logic        erq, evb, ok;
   logic [7:0]  exp_num = 8'd0;
   logic [8:0]  exp_addr;
   logic        prev_de = 1'b0, prev_hs = 1'b1;
   bit          hs_seen = 1'b0, de_fall_ok = 1'b0;
   int          cyc = 0, hs_fall = 0, de_fall = 0, de_cnt = 0;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         exp_num    = 8'd0;
         prev_de    = 1'b0;
         prev_hs    = 1'b1;
         hs_seen    = 1'b0;
         de_fall_ok = 1'b0;
         de_cnt     = 0;
      end else begin
         if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
         end else begin
            e    = '0;
            e.hs = 1'b1;
            e.vs = 1'b1;
         end
         ok = (vid_de === e.de) && (vid_hsync === e.hs) && (vid_vsync === e.vs) &&
              ({vid_r, vid_g, vid_b} === e.rgb);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL pixel v=%0d h=%0d: got de=%0b hs=%0b vs=%0b rgb=%06h want de=%0b hs=%0b vs=%0b rgb=%06h",
                     e.v, e.h, vid_de, vid_hsync, vid_vsync, {vid_r, vid_g, vid_b},
                     e.de, e.hs, e.vs, e.rgb);
         end
         if (cap_en && e.de && (e.v < 2)) cap[e.v[0]][e.h] = {vid_r, vid_g, vid_b};

         erq = (mh == 640) && (((mv % 2 == 1) && (mv < 479)) || (mv == 524));
         if (erq) exp_num = (mv == 524) ? 8'd0 : 8'((mv + 1) / 2);
         evb = (mh == 0) && (mv == 480);
         exp_addr = (mh < 640) ? 9'(mh / 2) : 9'd0;
         exp_pulses += int'(erq);
         got_pulses += int'(row_req);
         checks++;
         if ({row_req, row_req_num, vblank_start, rowram_rdaddr} !== {erq, exp_num, evb, exp_addr}) begin
            errors++;
            $display("FAIL ctrl v=%0d h=%0d: got req=%0b num=%0d vb=%0b addr=%0d want req=%0b num=%0d vb=%0b addr=%0d",
                     mv, mh, row_req, row_req_num, vblank_start, rowram_rdaddr, erq, exp_num, evb, exp_addr);
         end

         cyc++;
         if (prev_de && !vid_de) begin
            de_fall    = cyc;
            de_fall_ok = 1'b1;
         end
         if (vid_de) de_cnt++;
         if (prev_hs && !vid_hsync) begin
            if (hs_seen) begin
               check("line_period", 64'(cyc - hs_fall), 64'd800);
               check("de_per_line", 64'(de_cnt), 64'd640);
            end
            if (de_fall_ok) check("de_to_hsync", 64'(cyc - de_fall), 64'd16);
            hs_fall    = cyc;
            hs_seen    = 1'b1;
            de_cnt     = 0;
            de_fall_ok = 1'b0;
         end
         if (!prev_hs && vid_hsync && hs_seen) check("hsync_width", 64'(cyc - hs_fall), 64'd96);
         prev_de = vid_de;
         prev_hs = vid_hsync;
         if (errors >= 50) finish_tb();
      end
   end

   task automatic wait_pos(input int v, input int h);
      for (int i = 0; i < 60000; i++) begin
         @(negedge clk);
         if ((mv == v) && (mh == h)) return;
      end
      check("wait_timeout", 64'd1, 64'd0);
      finish_tb();
   endtask

   task automatic chk_reset(input string name);
      check(name, {vid_r, vid_g, vid_b, vid_de, vid_hsync, vid_vsync, row_req, row_req_num,
                   vblank_start, rowram_rdaddr},
            {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 9'd0});
   endtask

   vec_t vecs [4];

   initial begin
      vecs[0] = '{5,   10'h203, 9'h101, {32'h00AABBCC, 32'h00112233}, 24'hAABBCC};
      vecs[1] = '{6,   10'h202, 9'h101, {32'h00AABBCC, 32'h00112233}, 24'h112233};
      vecs[2] = '{0,   10'h001, 9'h000, {32'h00FF0000, 32'h0000FF00}, 24'hFF0000};
      vecs[3] = '{319, 10'h3FE, 9'h1FF, {32'h00123456, 32'h00ABCDEF}, 24'hABCDEF};
      for (int i = 0; i < 320; i++) row_mem[i] = 10'($urandom_range(0, 1023));
      for (int i = 0; i < 512; i++) pal_mem[i] = {$urandom, $urandom};
      foreach (vecs[i]) begin
         row_mem[vecs[i].x]  = vecs[i].idx;
         pal_mem[vecs[i].pa] = vecs[i].word;
      end

      repeat (3) @(negedge clk);
      #1 chk_reset("reset_state");
      #1 rst_n = 1'b1;

      wait_pos(4, 300);
      foreach (vecs[i]) begin
         for (int ln = 0; ln < 2; ln++) begin
            check($sformatf("colour_x%0d_line%0d_even", vecs[i].x, ln), 64'(cap[ln][2 * vecs[i].x]), 64'(vecs[i].rgb));
            check($sformatf("colour_x%0d_line%0d_odd", vecs[i].x, ln), 64'(cap[ln][2 * vecs[i].x + 1]), 64'(vecs[i].rgb));
         end
      end
      cap_en = 1'b0;

      check("pre_reset_de", 64'(vid_de), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset("async_reset");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1 check($sformatf("de_after_edge%0d", k), 64'(vid_de), (k == 3) ? 64'd1 : 64'd0);
      end

      wait_pos(40, 0);

      #2 rst_n = 1'b0;
      for (int i = 0; i < 320; i++) row_mem[i] = 10'h3FF;
      for (int i = 0; i < 512; i++) pal_mem[i] = {64{1'b1}};
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      wait_pos(2, 700);
      check("blank_rgb", 64'({vid_de, vid_r, vid_g, vid_b}), 64'h0_000000);
      wait_pos(3, 10);
      check("active_rgb", 64'({vid_de, vid_r, vid_g, vid_b}), 64'h1_FFFFFF);

      check("row_req_pulses", 64'(got_pulses), 64'(exp_pulses));
      finish_tb();
   end

endmodule

// File: doc/ppu_scanout.md
PPU_SCANOUT -- requirements
Module: ppu_scanout

Interface
REQ-001 SHALL have port clk, input, 1: pixel clock, one 640x480 pixel per cycle; sole clock.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port rowram_rdaddr, output, 9: row RAM read address (game-pixel x, 0..319).
REQ-004 SHALL have port rowram_rddata, input, 10: row RAM read data; colour index for the address presented one cycle earlier.
REQ-005 SHALL have port palram_rdaddr, output, 9: palette RAM read address (colour index bits 9:1).
REQ-006 SHALL have port palram_rddata, input, 64: palette RAM read data for the address presented one cycle earlier; bits 31:0 = even colour, 63:32 = odd colour; each colour word = {8'h00, R[7:0], G[7:0], B[7:0]}.
REQ-007 SHALL have ports vid_r, vid_g, vid_b, output, 8 each: pixel colour to HDMI transmitter.
REQ-008 SHALL have ports vid_hsync and vid_vsync, output, 1 each: active-low syncs.
REQ-009 SHALL have port vid_de, output, 1: active-video data enable.
REQ-010 SHALL have port row_req, output, 1: one-cycle pulse asking the renderer to fill the row RAM with game row row_req_num.
REQ-011 SHALL have port row_req_num, output, 8: game row index (0..239) valid while row_req is high.
REQ-012 SHALL have port vblank_start, output, 1: one-cycle pulse at the start of vertical blank.

Function
REQ-013 SHALL keep counters hcount (0..799) and vcount (0..524); hcount increments every cycle, wraps 799->0 and increments vcount; vcount wraps 524->0.
REQ-014 SHALL define active video as hcount<640 and vcount<480; game pixel = (hcount>>1, vcount>>1), giving 320x240 with 2x2 replication.
REQ-015 SHALL drive rowram_rdaddr = hcount[9:1] during active hcount, and 0 when hcount>=640.
REQ-016 SHALL drive palram_rdaddr = rowram_rddata[9:1] combinationally, and register rowram_rddata[0] one cycle to select the palette half.
REQ-017 SHALL register the selected colour word into vid_r/g/b, giving 3 cycles from a counter value to its pixel on the outputs.
REQ-018 SHALL force vid_r/g/b to 0 when the delayed active flag is 0.
REQ-019 SHALL assert hsync low for hcount 656..751 and vsync low for vcount 490..491, both computed from the counters and delayed 3 cycles to stay aligned with vid_de and the colour.
REQ-020 SHALL drive vid_de = active flag delayed 3 cycles.
REQ-021 SHALL pulse row_req for one cycle at hcount==640 when vcount is odd and vcount<479, with row_req_num=(vcount+1)>>1; no request when vcount==479.
REQ-022 SHALL pulse row_req at hcount==640 of vcount==524 with row_req_num=0.
REQ-023 SHALL hold row_req_num at its last value when row_req is low.
REQ-024 SHALL pulse vblank_start for one cycle at hcount==0, vcount==480 (undelayed).
REQ-025 SHALL not stall: there is no ready/valid input; RAM contents are sampled regardless of renderer progress.

Reset
REQ-026 SHALL, while rst_n is low, hold hcount=0, vcount=0, all pipeline stages cleared, vid_r/g/b=0, vid_de=0, vid_hsync=1, vid_vsync=1, row_req=0, row_req_num=0, vblank_start=0.
REQ-027 SHALL, on reset assertion mid-frame, clear immediately (asynchronously), and after release restart at pixel (0,0) with the first valid vid_de 3 cycles after the first clock edge.

Verification
REQ-028 SHALL verify reset: rst_n low mid-line -> all outputs at reset values within the same cycle; after release, vid_de rises on the 3rd rising edge.
REQ-029 SHALL verify timing: run two frames -> 800 cycles/line, 525 lines/frame, 640 vid_de cycles/line, hsync low 96 cycles, vsync low 2 lines, de-to-hsync gap 16 cycles.
REQ-030 SHALL verify colour path: row RAM model x=5 holds 10'h203, palette addr 9'h101 holds {32'h00AABBCC, 32'h00112233} -> output pixels 10 and 11 on that line show R=AA,G=BB,B=CC.
REQ-031 SHALL verify even index: row entry 10'h202 with same palette word -> R=11,G=22,B=33.
REQ-032 SHALL verify row requests: per frame exactly 240 row_req pulses, numbers 0 (vcount 524) then 1..239 (odd vcounts 1..477), none at vcount 479.
REQ-033 SHALL verify blanking: row RAM all 10'h3FF, palette all ones -> vid_r/g/b=0 whenever vid_de=0; vblank_start exactly once per frame at (0,480).
